// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: the segment vector type, the blank pattern and the
// active-low hex glyph table used by every display block.
package seg_pkg;

    // Segment order is {g,f,e,d,c,b,a}. A 0 lights the segment.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex_glyph(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host/display bundle for seg_scan_driver. The master writes display data and load
// strobes. The slave (the driver) returns status and the multiplexed segment/anode lines.
interface seg_scan_driver_if
    import seg_pkg::*;
#(
    parameter int unsigned NDIGITS = 8
);
    logic [4*NDIGITS-1:0] data;
    logic [NDIGITS-1:0]   dp;
    logic [NDIGITS-1:0]   digit_en;
    logic                 load;
    logic                 pending;
    logic                 frame_done;
    seg_t                 seg;
    logic                 dp_n;
    logic [NDIGITS-1:0]   an;

    modport master (
        output data, dp, digit_en, load,
        input  pending, frame_done, seg, dp_n, an
    );

    modport slave (
        input  data, dp, digit_en, load,
        output pending, frame_done, seg, dp_n, an
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       glyph
);

    // Pure table lookup; no blanking here, callers decide visibility.
    always_comb begin
        glyph = hex_glyph(nibble);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with double-buffered display data.
// A single-clock prescaler steps through one digit slot every SCAN_DIV cycles. The first
// GAP_CYCLES of each slot keep all anodes off to avoid ghosting. New data is committed to
// the display shadow only at a frame boundary.
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking (digit 0 always shown).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NDIGITS    = 8,
    parameter int unsigned SCAN_DIV   = 262144,
    parameter int unsigned GAP_CYCLES = 1024
) (
    input logic               clk,
    input logic               reset,
    seg_scan_driver_if.slave  bus
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

    // Scan position
    logic [PW-1:0] ph_q;
    logic [IW-1:0] idx_q;
    logic          wrap;
    logic          boundary;

    // Pending buffer and display shadow
    logic [NDIGITS-1:0][3:0] buf_data_q;
    logic [NDIGITS-1:0]      buf_dp_q;
    logic [NDIGITS-1:0]      buf_en_q;
    logic                    pending_q;
    logic                    pending_d;
    logic                    commit;
    logic [NDIGITS-1:0][3:0] sh_data_q;
    logic [NDIGITS-1:0]      sh_dp_q;
    logic [NDIGITS-1:0]      sh_en_q;

    // Per-digit visibility after enable and optional leading-zero blanking
    logic [NDIGITS-1:0] shown;

    // Current slot selection
    logic [3:0] cur_nib;
    logic       cur_shown;
    logic       cur_dp;
    seg_t       cur_glyph;
    logic       in_gap;

    // Registered outputs
    logic [NDIGITS-1:0] an_q;
    seg_t               seg_q;
    logic               dp_n_q;
    logic               frame_done_q;

    assign wrap     = (ph_q == PH_LAST);
    assign boundary = wrap && (idx_q == IDX_LAST);

    // A load in the boundary cycle is committed directly, so pending never rises for it.
    assign commit    = boundary && (pending_q || bus.load);
    assign pending_d = boundary ? 1'b0 : (pending_q || bus.load);

    // Prescaler and digit index advance once per slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_q  <= '0;
            idx_q <= '0;
        end else if (wrap) begin
            ph_q  <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            ph_q  <= ph_q + PW'(1);
        end
    end

    // Capture loads into the pending buffer; move to the shadow at a frame boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_data_q <= '0;
            buf_dp_q   <= '0;
            buf_en_q   <= '0;
            pending_q  <= 1'b0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_en_q    <= '0;
        end else begin
            if (bus.load) begin
                buf_data_q <= bus.data;
                buf_dp_q   <= bus.dp;
                buf_en_q   <= bus.digit_en;
            end
            if (commit) begin
                sh_data_q <= bus.load ? bus.data     : buf_data_q;
                sh_dp_q   <= bus.load ? bus.dp       : buf_dp_q;
                sh_en_q   <= bus.load ? bus.digit_en : buf_en_q;
            end
            pending_q <= pending_d;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic nz_seen;

    // Blank a digit when it and every higher digit are zero; digit 0 always survives
    always_comb begin
        nz_seen = 1'b0;
        shown   = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            nz_seen  = nz_seen | (sh_data_q[i] != 4'h0);
            shown[i] = sh_en_q[i] & (nz_seen | (i == 0));
        end
    end
`else
    // Only the per-digit enable blanks a digit
    always_comb begin
        shown = sh_en_q;
    end
`endif

    assign cur_nib   = sh_data_q[idx_q];
    assign cur_shown = shown[idx_q];
    assign cur_dp    = sh_dp_q[idx_q];

    generate
        if (GAP_CYCLES == 0) begin : g_no_gap
            assign in_gap = 1'b0;
        end else begin : g_gap
            assign in_gap = (ph_q < PW'(GAP_CYCLES));
        end
    endgenerate

    seg_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    // Output stage: one cycle behind (ph, idx); dead time and hidden digits drive blank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= boundary;
            if (in_gap || !cur_shown) begin
                an_q   <= '1;
                seg_q  <= SEG_BLANK;
                dp_n_q <= 1'b1;
            end else begin
                an_q   <= ~(NDIGITS'(1) << idx_q);
                seg_q  <= cur_glyph;
                dp_n_q <= ~cur_dp;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with NDIGITS=4, SCAN_DIV=8, GAP_CYCLES=2.
// A cycle-count model predicts every output after each clock edge. Directed steps add
// literal expectations from the glyph table.
module tb_seg_scan_driver;

    localparam int unsigned ND    = 4;
    localparam int unsigned SD    = 8;
    localparam int unsigned GAP   = 2;
    localparam int unsigned FRAME = ND * SD;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.NDIGITS(ND)) bus ();

    seg_scan_driver #(
        .NDIGITS    (ND),
        .SCAN_DIV   (SD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          cnt = 0;
    logic [15:0] m_buf_d, m_sh_d;
    logic [3:0]  m_buf_dp, m_buf_en, m_sh_dp, m_sh_en;
    bit          m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn, e_fd, e_pend;

    function automatic bit digit_visible(input logic [15:0] d, input logic [3:0] en, input int k);
        if (!en[k]) return 1'b0;
`ifdef SEG_SCAN_LZB_EN
        if (k != 0 && (d >> (4 * k)) == 16'h0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        int t, slot, off;
        logic [3:0] nib;
        if (!reset) begin
            cnt = 0;
            m_pend = 0;
            m_buf_d = '0; m_buf_dp = '0; m_buf_en = '0;
            m_sh_d = '0;  m_sh_dp = '0;  m_sh_en = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0; e_pend = 1'b0;
        end else begin
            t    = cnt;
            slot = (t / SD) % ND;
            off  = t % SD;
            nib  = m_sh_d[4*slot +: 4];
            if (off >= GAP && digit_visible(m_sh_d, m_sh_en, slot)) begin
                e_an  = 4'hF & ~(4'b0001 << slot);
                e_seg = glyph_tab[nib];
                e_dpn = ~m_sh_dp[slot];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
            end
            e_fd = ((t % FRAME) == FRAME - 1);
            if (bus.load) begin
                m_buf_d = bus.data; m_buf_dp = bus.dp; m_buf_en = bus.digit_en;
            end
            if (e_fd && (m_pend || bus.load)) begin
                m_sh_d = m_buf_d; m_sh_dp = m_buf_dp; m_sh_en = m_buf_en;
                m_pend = 0;
            end else if (bus.load) begin
                m_pend = 1;
            end
            e_pend = m_pend;
            cnt++;
        end
        #1;
        check("model_an", bus.an, e_an);
        check("model_seg", bus.seg, e_seg);
        check("model_dp_n", bus.dp_n, e_dpn);
        check("model_frame_done", bus.frame_done, e_fd);
        check("model_pending", bus.pending, e_pend);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] p);
        @(negedge clk);
        bus.data = d; bus.digit_en = en; bus.dp = p; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_fd();
        for (int k = 0; k < FRAME + 4; k++) begin
            tick();
            if (bus.frame_done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_frame_done: got timeout want pulse within %0d cycles", FRAME + 4);
    endtask

    logic [3:0] an_exp [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_exp [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};

    initial begin
        int period, bad_an, dp_lo;
        bus.load = 1'b0; bus.data = '0; bus.dp = '0; bus.digit_en = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Blank after reset, frame_done every FRAME cycles
        tick();
        check("reset_an", bus.an, 4'hF);
        check("reset_seg", bus.seg, 7'h7F);
        wait_fd();
        period = 0;
        for (int k = 0; k < FRAME + 4; k++) begin
            tick();
            period++;
            if (bus.frame_done === 1'b1) break;
        end
        check("fd_period", period, 32);
        check("blank_an", bus.an, 4'hF);

        // 1A3F, all enabled
        do_load(16'h1A3F, 4'hF, 4'h0);
        tick();
        check("pending_set", bus.pending, 1'b1);
        wait_fd();
        tick(); tick();
        check("gap_an", bus.an, 4'hF);
        check("pending_clr", bus.pending, 1'b0);
        tick();
        for (int s = 0; s < 4; s++) begin
            if (s != 0) repeat (8) tick();
            check("slot_an", bus.an, an_exp[s]);
            check("slot_seg", bus.seg, seg_exp[s]);
            check("slot_dp_n", bus.dp_n, 1'b1);
        end

        // Two loads in one frame: last wins
        do_load(16'h1111, 4'hF, 4'h0);
        do_load(16'h2222, 4'hF, 4'h0);
        tick();
        check("pending_two", bus.pending, 1'b1);
        wait_fd();
        repeat (3) tick();
        check("last_wins_seg", bus.seg, 7'h24);

        // Load exactly on the boundary cycle
        wait_fd();
        repeat (31) tick();
        @(negedge clk);
        bus.data = 16'h5555; bus.digit_en = 4'hF; bus.dp = 4'h0; bus.load = 1'b1;
        tick();
        check("bnd_fd", bus.frame_done, 1'b1);
        check("bnd_pending", bus.pending, 1'b0);
        @(negedge clk);
        bus.load = 1'b0;
        repeat (3) tick();
        check("bnd_seg", bus.seg, 7'h12);
        check("bnd_pending2", bus.pending, 1'b0);

        // Partial enable with decimal points
        do_load(16'h8888, 4'b0101, 4'b1111);
        wait_fd();
        bad_an = 0;
        dp_lo  = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (bus.an[1] == 1'b0 || bus.an[3] == 1'b0) bad_an++;
            if (bus.dp_n == 1'b0) dp_lo++;
        end
        check("en_an13_low", bad_an, 0);
        check("en_dp_low", dp_lo, 12);

        // Zero handling (leading-zero blanking when built with it)
        do_load(16'h0040, 4'hF, 4'hF);
        wait_fd();
        repeat (3) tick();
        check("z_d0_seg", bus.seg, 7'h40);
        check("z_d0_an", bus.an, 4'b1110);
        repeat (8) tick();
        check("z_d1_seg", bus.seg, 7'h19);
        repeat (8) tick();
`ifdef SEG_SCAN_LZB_EN
        check("z_d2_an", bus.an, 4'hF);
        check("z_d2_seg", bus.seg, 7'h7F);
        check("z_d2_dp_n", bus.dp_n, 1'b1);
`else
        check("z_d2_an", bus.an, 4'b1011);
        check("z_d2_seg", bus.seg, 7'h40);
`endif
        do_load(16'h0000, 4'hF, 4'h0);
        wait_fd();
        repeat (3) tick();
        check("zz_d0_seg", bus.seg, 7'h40);
        repeat (8) tick();
`ifdef SEG_SCAN_LZB_EN
        check("zz_d1_an", bus.an, 4'hF);
`else
        check("zz_d1_an", bus.an, 4'b1101);
`endif

        // Reset mid-slot with a load pending
        wait_fd();
        repeat (4) tick();
        do_load(16'h9999, 4'hF, 4'hF);
        check("pre_rst_pending", bus.pending, 1'b1);
        check("pre_rst_an", bus.an, 4'b1110);
        reset = 1'b0;
        #1;
        check("rst_async_an", bus.an, 4'hF);
        check("rst_async_seg", bus.seg, 7'h7F);
        check("rst_async_dp_n", bus.dp_n, 1'b1);
        check("rst_async_pending", bus.pending, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_fd();
        repeat (4) tick();
        check("post_rst_an", bus.an, 4'hF);
        repeat (FRAME) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
